// File: rtl/lf_sff_scan_ctrl_if.sv
// rtl/lf_sff_scan_ctrl_if.sv - control, configuration and strobe bundle of the LF_SFF scan sequencer
interface lf_sff_scan_ctrl_if #(
    parameter int CNT_WIDTH  = 8,
    parameter int TIME_WIDTH = 8
);
    logic                  START;
    logic                  ABORT;
    logic                  HOLD;
    logic [CNT_WIDTH-1:0]  NUM_ROWS;
    logic [CNT_WIDTH-1:0]  NUM_COLS;
    logic [TIME_WIDTH-1:0] T_RESET;
    logic [TIME_WIDTH-1:0] T_SETTLE;
    logic [TIME_WIDTH-1:0] T_SAMPLE;
    logic                  RESET_ROW_CNT;
    logic                  RESET_COL_CNT;
    logic                  ROW_RESET;
    logic                  CLK_ROW;
    logic                  CLK_COL;
    logic                  ADC_SYNC;
    logic [CNT_WIDTH-1:0]  ROW_IDX;
    logic [CNT_WIDTH-1:0]  COL_IDX;
    logic                  BUSY;
    logic                  DONE;
    logic                  CFG_ERR;

    modport master (
        output START, ABORT, HOLD, NUM_ROWS, NUM_COLS, T_RESET, T_SETTLE, T_SAMPLE,
        input  RESET_ROW_CNT, RESET_COL_CNT, ROW_RESET, CLK_ROW, CLK_COL, ADC_SYNC,
        input  ROW_IDX, COL_IDX, BUSY, DONE, CFG_ERR
    );

    modport slave (
        input  START, ABORT, HOLD, NUM_ROWS, NUM_COLS, T_RESET, T_SETTLE, T_SAMPLE,
        output RESET_ROW_CNT, RESET_COL_CNT, ROW_RESET, CLK_ROW, CLK_COL, ADC_SYNC,
        output ROW_IDX, COL_IDX, BUSY, DONE, CFG_ERR
    );
endinterface

// File: rtl/lf_sff_scan_ctrl.sv
// rtl/lf_sff_scan_ctrl.sv - parameterised raster-scan sequencer for LF_SFF pixel matrix readout
module lf_sff_scan_ctrl #(
    parameter int CNT_WIDTH  = 8,
    parameter int TIME_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    lf_sff_scan_ctrl_if.slave  bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CNT_RST = 4'd1;
    localparam logic [3:0] S_ROW_RST = 4'd2;
    localparam logic [3:0] S_SETTLE  = 4'd3;
    localparam logic [3:0] S_WAIT    = 4'd4;
    localparam logic [3:0] S_SAMPLE  = 4'd5;
    localparam logic [3:0] S_COL_HI  = 4'd6;
    localparam logic [3:0] S_COL_LO  = 4'd7;
    localparam logic [3:0] S_ROW_HI  = 4'd8;
    localparam logic [3:0] S_ROW_LO  = 4'd9;
    localparam logic [3:0] S_FIN     = 4'd10;

    logic [3:0]            state_q, state_d;
    logic [TIME_WIDTH-1:0] timer_q, timer_d;
    logic [CNT_WIDTH-1:0]  row_idx_q, row_idx_d, col_idx_q, col_idx_d;
    logic [CNT_WIDTH-1:0]  num_rows_q, num_rows_d, num_cols_q, num_cols_d;
    logic [TIME_WIDTH-1:0] t_reset_q, t_reset_d, t_settle_q, t_settle_d, t_sample_q, t_sample_d;
    logic rst_row_cnt_q, rst_row_cnt_d, rst_col_cnt_q, rst_col_cnt_d;
    logic row_reset_q, row_reset_d, clk_row_q, clk_row_d, clk_col_q, clk_col_d;
    logic adc_sync_q, adc_sync_d, busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic go_sample;

    // A zero duration still occupies one cycle, so it loads the same value as one.
    function automatic logic [TIME_WIDTH-1:0] t_load(input logic [TIME_WIDTH-1:0] t);
        return (t == '0) ? '0 : t - TIME_WIDTH'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        row_idx_d  = row_idx_q;
        col_idx_d  = col_idx_q;
        num_rows_d = num_rows_q;
        num_cols_d = num_cols_q;
        t_reset_d  = t_reset_q;
        t_settle_d = t_settle_q;
        t_sample_d = t_sample_q;
        cfg_err_d  = 1'b0;
        go_sample  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    if (bus.NUM_ROWS == '0 || bus.NUM_COLS == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        num_rows_d = bus.NUM_ROWS;
                        num_cols_d = bus.NUM_COLS;
                        t_reset_d  = bus.T_RESET;
                        t_settle_d = bus.T_SETTLE;
                        t_sample_d = bus.T_SAMPLE;
                        state_d    = S_CNT_RST;
                        timer_d    = TIME_WIDTH'(1);
                    end
                end
            end
            S_CNT_RST: begin
                if (timer_q == '0) begin
                    state_d = S_ROW_RST;
                    timer_d = t_load(t_reset_q);
                end else begin
                    timer_d = timer_q - TIME_WIDTH'(1);
                end
            end
            S_ROW_RST: begin
                if (timer_q == '0) begin
                    state_d = S_SETTLE;
                    timer_d = t_load(t_settle_q);
                end else begin
                    timer_d = timer_q - TIME_WIDTH'(1);
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) go_sample = 1'b1;
                else               timer_d = timer_q - TIME_WIDTH'(1);
            end
            S_WAIT: begin
                if (!bus.HOLD) begin
                    state_d = S_SAMPLE;
                    timer_d = t_load(t_sample_q);
                end
            end
            S_SAMPLE: begin
                if (timer_q != '0)                           timer_d = timer_q - TIME_WIDTH'(1);
                else if (col_idx_q < num_cols_q - CNT_WIDTH'(1)) state_d = S_COL_HI;
                else if (row_idx_q < num_rows_q - CNT_WIDTH'(1)) state_d = S_ROW_HI;
                else                                         state_d = S_FIN;
            end
            S_COL_HI: begin
                state_d   = S_COL_LO;
                col_idx_d = col_idx_q + CNT_WIDTH'(1);
            end
            S_COL_LO: go_sample = 1'b1;
            S_ROW_HI: begin
                state_d   = S_ROW_LO;
                row_idx_d = row_idx_q + CNT_WIDTH'(1);
                col_idx_d = '0;
            end
            S_ROW_LO: begin
                state_d = S_ROW_RST;
                timer_d = t_load(t_reset_q);
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // HOLD is only looked at on the way into a sample; a running sample always completes.
        if (go_sample) begin
            if (bus.HOLD) begin
                state_d = S_WAIT;
            end else begin
                state_d = S_SAMPLE;
                timer_d = t_load(t_sample_q);
            end
        end

        if (bus.ABORT && state_q != S_IDLE) state_d = S_IDLE;
        if (state_d == S_IDLE) begin
            row_idx_d = '0;
            col_idx_d = '0;
        end

        // Strobes are decoded from the next state so every output is a flop aligned with its state.
        rst_row_cnt_d = (state_d == S_CNT_RST);
        rst_col_cnt_d = (state_d == S_CNT_RST) || (state_d == S_ROW_HI);
        row_reset_d   = (state_d == S_ROW_RST);
        clk_row_d     = (state_d == S_ROW_HI);
        clk_col_d     = (state_d == S_COL_HI);
        adc_sync_d    = (state_d == S_SAMPLE) && (state_q != S_SAMPLE);
        busy_d        = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d        = (state_d == S_FIN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            row_idx_q     <= '0;
            col_idx_q     <= '0;
            num_rows_q    <= '0;
            num_cols_q    <= '0;
            t_reset_q     <= '0;
            t_settle_q    <= '0;
            t_sample_q    <= '0;
            rst_row_cnt_q <= 1'b0;
            rst_col_cnt_q <= 1'b0;
            row_reset_q   <= 1'b0;
            clk_row_q     <= 1'b0;
            clk_col_q     <= 1'b0;
            adc_sync_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            row_idx_q     <= row_idx_d;
            col_idx_q     <= col_idx_d;
            num_rows_q    <= num_rows_d;
            num_cols_q    <= num_cols_d;
            t_reset_q     <= t_reset_d;
            t_settle_q    <= t_settle_d;
            t_sample_q    <= t_sample_d;
            rst_row_cnt_q <= rst_row_cnt_d;
            rst_col_cnt_q <= rst_col_cnt_d;
            row_reset_q   <= row_reset_d;
            clk_row_q     <= clk_row_d;
            clk_col_q     <= clk_col_d;
            adc_sync_q    <= adc_sync_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign bus.RESET_ROW_CNT = rst_row_cnt_q;
    assign bus.RESET_COL_CNT = rst_col_cnt_q;
    assign bus.ROW_RESET     = row_reset_q;
    assign bus.CLK_ROW       = clk_row_q;
    assign bus.CLK_COL       = clk_col_q;
    assign bus.ADC_SYNC      = adc_sync_q;
    assign bus.ROW_IDX       = row_idx_q;
    assign bus.COL_IDX       = col_idx_q;
    assign bus.BUSY          = busy_q;
    assign bus.DONE          = done_q;
    assign bus.CFG_ERR       = cfg_err_q;
endmodule
